// File: rtl/sync_gen_pkg.sv
// Shared types and default geometry for the sync signal generator.
// Frame regions, default frame size, counter width helper.
package sync_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_V_PRE,
    ST_ACTIVE,
    ST_V_POST
  } state_t;

  localparam int DEF_COLS    = 320;
  localparam int DEF_ROWS    = 240;
  localparam int DEF_H_BLANK = 64;
  localparam int DEF_V_PRE   = 2;
  localparam int DEF_V_POST  = 8;

  function automatic int cnt_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/sync_gen_line_timer.sv
// Horizontal position counter for one line.
// Holds at zero while stopped; pulses wrap on the last cycle of a line.
module sync_gen_line_timer
  import sync_gen_pkg::*;
#(
  parameter int LINE = DEF_COLS + DEF_H_BLANK,
  parameter int HW   = cnt_bits(LINE)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  output logic [HW-1:0] h,
  output logic          wrap
);

  localparam logic [HW-1:0] H_LAST = HW'(LINE - 1);

  logic [HW-1:0] h_q;
  logic [HW-1:0] h_d;

  assign wrap = run && (h_q == H_LAST);
  assign h    = h_q;

  // Next horizontal position: count while running, wrap at end of line.
  always_comb begin
    h_d = h_q;
    if (!run || wrap) begin
      h_d = '0;
    end else begin
      h_d = h_q + HW'(1);
    end
  end

  // Horizontal position register.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_q <= '0;
    end else begin
      h_q <= h_d;
    end
  end

endmodule

// File: rtl/sync_signals_generator.sv
// Frame/row sync generator: region FSM, line counter, output decode.
// All outputs are pure decodes of registered state and counters.
module sync_signals_generator
  import sync_gen_pkg::*;
#(
  parameter int COLS     = DEF_COLS,
  parameter int H_BLANK  = DEF_H_BLANK,
  parameter int ROWS     = DEF_ROWS,
  parameter int V_PRE    = DEF_V_PRE,
  parameter int V_POST   = DEF_V_POST,
  parameter int COL_BITS = 9,
  parameter int ROW_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  output logic                fsync_out,
  output logic                rsync_out,
  output logic [COL_BITS-1:0] col_idx,
  output logic [ROW_BITS-1:0] row_idx,
  output logic                frame_start,
  output logic                frame_done
);

  localparam int LINE = COLS + H_BLANK;
  localparam int HW   = cnt_bits(LINE);
  localparam int VMAX = max3(ROWS, V_PRE, V_POST);
  localparam int VW   = cnt_bits(VMAX);

  localparam logic [VW-1:0] PRE_LAST  = VW'(V_PRE - 1);
  localparam logic [VW-1:0] ROW_LAST  = VW'(ROWS - 1);
  localparam logic [VW-1:0] POST_LAST = VW'(V_POST - 1);
  localparam logic [HW:0]   COLS_C    = (HW + 1)'(COLS);

  localparam state_t FIRST = (V_PRE > 0) ? ST_V_PRE : ST_ACTIVE;

  if (ROWS > 2 ** ROW_BITS || COLS > 2 ** COL_BITS) begin : g_bad_geom
    $error("ROWS/COLS do not fit in ROW_BITS/COL_BITS");
  end

  state_t        state_q;
  state_t        state_d;
  logic [VW-1:0] v_q;
  logic [VW-1:0] v_d;
  logic [HW-1:0] h;
  logic          wrap;
  logic          run;

  assign run = (state_q != ST_IDLE);

  sync_gen_line_timer #(
    .LINE (LINE),
    .HW   (HW)
  ) u_line_timer (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .h     (h),
    .wrap  (wrap)
  );

  // Region sequencing and line count, advanced on each line wrap.
  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    unique case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = FIRST;
          v_d     = '0;
        end
      end
      ST_V_PRE: begin
        if (wrap) begin
          if (v_q == PRE_LAST) begin
            state_d = ST_ACTIVE;
            v_d     = '0;
          end else begin
            v_d = v_q + VW'(1);
          end
        end
      end
      ST_ACTIVE: begin
        if (wrap) begin
          if (v_q == ROW_LAST) begin
            v_d = '0;
            if (V_POST > 0) begin
              state_d = ST_V_POST;
            end else begin
              state_d = en ? FIRST : ST_IDLE;
            end
          end else begin
            v_d = v_q + VW'(1);
          end
        end
      end
      ST_V_POST: begin
        if (wrap) begin
          if (v_q == POST_LAST) begin
            v_d     = '0;
            state_d = en ? FIRST : ST_IDLE;
          end else begin
            v_d = v_q + VW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        v_d     = '0;
      end
    endcase
  end

  // State and line counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      v_q     <= '0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
    end
  end

  assign fsync_out = (state_q == ST_ACTIVE);
  assign rsync_out = fsync_out && ({1'b0, h} < COLS_C);
  assign col_idx   = rsync_out ? COL_BITS'(h) : '0;
  assign row_idx   = fsync_out ? ROW_BITS'(v_q) : '0;

  assign frame_start = fsync_out && (h == '0) && (v_q == '0);

  assign frame_done = wrap && ((V_POST > 0) ?
    ((state_q == ST_V_POST) && (v_q == POST_LAST)) :
    ((state_q == ST_ACTIVE) && (v_q == ROW_LAST)));

endmodule

// File: tb/tb_sync_signals_generator.sv
// Bench: two geometries driven together, checked against a frame-position model.
// Model tracks one linear position per frame and derives outputs arithmetically.
module tb_sync_signals_generator;

  localparam int C  = 4;
  localparam int HB = 2;
  localparam int R  = 3;
  localparam int LN = C + HB;
  localparam int FA = (1 + R + 1) * LN;
  localparam int FB = R * LN;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;

  logic       a_fsync, a_rsync, a_fs, a_fd;
  logic [2:0] a_col;
  logic [1:0] a_row;
  logic       b_fsync, b_rsync, b_fs, b_fd;
  logic [2:0] b_col;
  logic [1:0] b_row;
  logic [8:0] out_a, out_b;

  int ncmp = 0;
  int nfail = 0;
  int cyc = 0;
  bit run_a = 0;
  bit run_b = 0;
  int p_a = 0;
  int p_b = 0;
  logic [4:0] idxq[$];

  always #5 clk = ~clk;

  assign out_a = {a_fsync, a_rsync, a_col, a_row, a_fs, a_fd};
  assign out_b = {b_fsync, b_rsync, b_col, b_row, b_fs, b_fd};

  sync_signals_generator #(
    .COLS(C), .H_BLANK(HB), .ROWS(R), .V_PRE(1), .V_POST(1),
    .COL_BITS(3), .ROW_BITS(2)
  ) dut_a (
    .clk(clk), .reset(reset), .en(en),
    .fsync_out(a_fsync), .rsync_out(a_rsync),
    .col_idx(a_col), .row_idx(a_row),
    .frame_start(a_fs), .frame_done(a_fd)
  );

  sync_signals_generator #(
    .COLS(C), .H_BLANK(HB), .ROWS(R), .V_PRE(0), .V_POST(0),
    .COL_BITS(3), .ROW_BITS(2)
  ) dut_b (
    .clk(clk), .reset(reset), .en(en),
    .fsync_out(b_fsync), .rsync_out(b_rsync),
    .col_idx(b_col), .row_idx(b_row),
    .frame_start(b_fs), .frame_done(b_fd)
  );

  function automatic logic [8:0] model(bit run, int p, int vpre, int frame);
    int line, h, row;
    logic fs, rs, fst, fd;
    logic [2:0] col;
    logic [1:0] rw;
    fs = 0; rs = 0; fst = 0; fd = 0; col = '0; rw = '0;
    if (run) begin
      line = p / LN;
      h    = p % LN;
      row  = line - vpre;
      fs   = (row >= 0) && (row < R);
      rs   = fs && (h < C);
      if (rs) col = 3'(h);
      if (fs) rw = 2'(row);
      fst  = fs && (row == 0) && (h == 0);
      fd   = (p == frame - 1);
    end
    return {fs, rs, col, rw, fst, fd};
  endfunction

  task automatic adv(inout bit run, inout int p, input int frame,
                     input bit e, input bit r);
    if (r) begin
      run = 0; p = 0;
    end else if (!run) begin
      if (e) begin run = 1; p = 0; end
    end else if (p == frame - 1) begin
      p = 0;
      if (!e) run = 0;
    end else begin
      p = p + 1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input bit e, input bit r);
    en = e;
    reset = r;
    @(posedge clk);
    adv(run_a, p_a, FA, e, r);
    adv(run_b, p_b, FB, e, r);
    #1;
    cyc++;
    check("model_a", 32'(out_a), 32'(model(run_a, p_a, 1, FA)));
    check("model_b", 32'(out_b), 32'(model(run_b, p_b, 0, FB)));
  endtask

  initial begin
    logic ex_f, ex_r;
    // reset and idle
    step(0, 1);
    step(0, 1);
    check("rst_a", 32'(out_a), 32'd0);
    check("rst_b", 32'(out_b), 32'd0);
    for (int k = 0; k < 3; k++) step(0, 0);
    check("idle_a", 32'(out_a), 32'd0);

    // continuous run, two frames of A
    cyc = 0;
    for (int k = 0; k < 40; k++) begin
      step(1, 0);
      ex_f = (cyc >= 7 && cyc <= 24) || (cyc >= 37);
      ex_r = (cyc >= 7 && cyc <= 10) || (cyc >= 13 && cyc <= 16) ||
             (cyc >= 19 && cyc <= 22) || (cyc >= 37 && cyc <= 40);
      check("a_fsync", 32'(a_fsync), 32'(ex_f));
      check("a_rsync", 32'(a_rsync), 32'(ex_r));
      check("a_fstart", 32'(a_fs), 32'(cyc == 7 || cyc == 37));
      check("a_fdone", 32'(a_fd), 32'(cyc == 30));
      check("b_fsync", 32'(b_fsync), 32'd1);
      check("b_fdone", 32'(b_fd), 32'(cyc % 18 == 0));
      check("b_fd_col5", 32'(b_fd),
            32'(p_b % LN == 5 && p_b / LN == 2));
      if (a_rsync) idxq.push_back({a_row, a_col});
    end
    check("idx_count", 32'(idxq.size()), 32'd16);
    for (int i = 0; i < idxq.size() && i < 16; i++) begin
      check("idx_seq", 32'(idxq[i]), 32'({2'((i / C) % R), 3'(i % C)}));
    end
    for (int k = 0; k < 60; k++) step(0, 0);
    check("drain_a", 32'(out_a), 32'd0);
    check("drain_b", 32'(out_b), 32'd0);

    // en dropped at cycle 12
    step(0, 1);
    cyc = 0;
    for (int k = 0; k < 40; k++) begin
      step(cyc < 12, 0);
      check("drop_fdone", 32'(a_fd), 32'(cyc == 30));
      if (cyc >= 31) check("drop_idle", 32'(out_a), 32'd0);
    end

    // reset mid row 1
    step(0, 1);
    cyc = 0;
    while (cyc < 15) step(1, 0);
    step(1, 1);
    check("abort_a", 32'(out_a), 32'd0);
    check("abort_b", 32'(out_b), 32'd0);
    while (cyc < 30) begin
      step(1, 0);
      check("restart_fs", 32'(a_fs), 32'(cyc == 23));
    end

    // randomized en and reset
    for (int k = 0; k < 500; k++) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 59) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/sync_signals_generator.md
SYNC_SIGNALS_GENERATOR -- requirements
Module: sync_signals_generator

Interface
REQ-001 Parameter COLS, default 320: active pixels per row.
REQ-002 Parameter H_BLANK, default 64: blank cycles after the active pixels of each line.
REQ-003 Parameter ROWS, default 240: active rows per frame.
REQ-004 Parameter V_PRE, default 2: blank lines before the first active row.
REQ-005 Parameter V_POST, default 8: blank lines after the last active row.
REQ-006 Parameter COL_BITS, default 9, and ROW_BITS, default 8: widths of the column and row index outputs.
REQ-007 Port clk, input, 1: the only clock; all state updates on posedge clk.
REQ-008 Port reset, input, 1: synchronous, active-high reset.
REQ-009 Port en, input, 1: run request; sampled only at frame boundaries.
REQ-010 Port fsync_out, output, 1: frame-valid; high for every cycle of every active line.
REQ-011 Port rsync_out, output, 1: row-valid; high while the column index < COLS on an active line.
REQ-012 Port col_idx, output, COL_BITS: active column, 0..COLS-1; 0 when rsync_out is low.
REQ-013 Port row_idx, output, ROW_BITS: active row, 0..ROWS-1; 0 when fsync_out is low.
REQ-014 Port frame_start, output, 1: one-cycle pulse on the first active pixel of a frame.
REQ-015 Port frame_done, output, 1: one-cycle pulse on the last cycle of the V_POST region.

Function
REQ-016 The FSM SHALL have the states IDLE, V_PRE, ACTIVE and V_POST; the horizontal counter h (0..COLS+H_BLANK-1) and the line counter v SHALL run in every state except IDLE.
REQ-017 IDLE with en=1 in cycle N SHALL enter V_PRE in cycle N+1 with h=0 and v=0; IDLE with en=0 SHALL stay in IDLE.
REQ-018 h SHALL wrap to 0 after COLS+H_BLANK-1, and v SHALL increment on each wrap.
REQ-019 On the wrap that ends line V_PRE-1 the FSM SHALL enter ACTIVE with v=0.
REQ-020 On the wrap that ends line ROWS-1 of ACTIVE the FSM SHALL enter V_POST with v=0.
REQ-021 When V_PRE=0 or V_POST=0 the corresponding region SHALL be skipped entirely, with no extra cycle.
REQ-022 At the end of V_POST the FSM SHALL go to V_PRE (or to ACTIVE if V_PRE=0) when en=1, and to IDLE when en=0; the transition SHALL occur without a gap cycle.
REQ-023 Deasserting en mid-frame SHALL NOT truncate the frame; the current frame SHALL complete through V_POST.
REQ-024 All outputs SHALL be Moore decodes of the registered state and counters, with no combinational path from en or reset to any output.
REQ-025 fsync_out SHALL be (state==ACTIVE).
REQ-026 rsync_out SHALL be fsync_out AND (h<COLS).
REQ-027 col_idx SHALL equal h and row_idx SHALL equal v while their respective sync outputs are high, and SHALL be 0 otherwise.
REQ-028 frame_start SHALL be ACTIVE with h=0 and v=0.
REQ-029 frame_done SHALL be V_POST with v=V_POST-1 and h=COLS+H_BLANK-1; when V_POST=0 it SHALL instead pulse on the last cycle of ACTIVE row ROWS-1.
REQ-030 Counter widths SHALL be sized by clog2 of their terminal counts, and index outputs SHALL be zero-extended or truncated to COL_BITS/ROW_BITS.
REQ-031 ROWS > 2^ROW_BITS or COLS > 2^COL_BITS SHALL be rejected at elaboration.

Reset
REQ-032 A cycle with reset=1 SHALL force state IDLE, h=0 and v=0, and every output SHALL be 0 in the following cycle.
REQ-033 reset SHALL take priority over en and over every counter update.
REQ-034 Reset asserted mid-line or mid-frame SHALL abort immediately, with no partial-line completion.
REQ-035 After reset release the block SHALL wait in IDLE until en is sampled high.

Structure
REQ-036 The shared package sync_gen_pkg SHALL hold the state enumeration and the default geometry constants (320, 240, 64, 2, 8).
REQ-037 One sub-module, sync_gen_line_timer, SHALL hold h and its wrap pulse; the FSM, v and the output decode SHALL live in the top module.

Verification (COLS=4, H_BLANK=2, ROWS=3, V_PRE=1, V_POST=1; line = 6 cycles, frame = 30 cycles)
REQ-038 Test: en=1 sampled at cycle 0 -> fsync rises at cycle 7; rsync high cycles 7-10, 13-16 and 19-22; fsync falls at cycle 25; frame_start at cycle 7; frame_done at cycle 30.
REQ-039 Test: en held 1 -> the second frame_start falls at cycle 37 (30-cycle period) and no idle cycle appears between frames.
REQ-040 Test: en dropped at cycle 12 -> the frame completes (frame_done at cycle 30), the block is IDLE at cycle 31 and all outputs stay 0 afterwards.
REQ-041 Test: reset pulsed at cycle 15 (mid-row 1) -> all outputs are 0 at cycle 16; with en=1, a new frame_start follows 7 cycles after reset release.
REQ-042 Test: V_PRE=0 and V_POST=0 -> fsync high for 18 consecutive cycles per frame, frame_done in the same cycle as col 5 of row 2, and back-to-back frames.
REQ-043 Test: a col_idx/row_idx scoreboard checks the sequence 0..3 within rows 0..2 and that both indices are 0 whenever their sync output is low.
